mips_inst_injector: RTL and testbench
=====================================

Name: mips_inst_injector

Overview:
- Instruction source for the MIPS single-cycle core's external-instruction port (extInst/extInst_en); the producer end of the interface the core consumes.
- Buffers host-supplied 32-bit instructions in a FIFO.
- Issues one instruction per clock while enabled.
- Emits a retire trace pairing each issued instruction with the core's pc_current, for scoreboarding.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
CNT_W, 16, width of issue and bubble counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
in_valid  input  1  host offers in_data
in_data  input  32  instruction word to enqueue
in_ready  output  1  FIFO can accept; equals !full
run  input  1  level; 1 = stream instructions to the core
pc_current  input  32  core's current PC (from MIPS pc_current)
ext_inst  output  32  instruction to core extInst
ext_inst_en  output  1  to core extInst_en
retire_valid  output  1  one-cycle pulse per real instruction executed
retire_pc  output  32  PC at which retired instruction executed
retire_inst  output  32  retired instruction word
busy  output  1  FSM in RUN
issued_count  output  CNT_W  real instructions issued since reset
bubble_count  output  CNT_W  NOPs inserted since reset

Behaviour:
- Reset (rst=0, async): FIFO emptied (pointers and count = 0), FSM = IDLE, ext_inst=0, ext_inst_en=0, retire_valid=0, retire_pc=0, retire_inst=0, busy=0, both counters=0. in_ready=1 once reset releases. Reset mid-RUN discards FIFO contents and any pending retire.
- FIFO push: when in_valid && in_ready, in_data is written at the clock edge. in_ready is combinational from count only; no push-through when full (a pop in the same cycle does not raise in_ready).
- Simultaneous push and pop with count unchanged is legal at any non-full count. Pointers wrap modulo DEPTH.
- FSM states IDLE and RUN; all outputs registered.
- IDLE: ext_inst_en=0, ext_inst=0. run=1 at an edge moves to RUN; no issue occurs on that same edge.
- RUN, each edge, with run=1:
  - FIFO non-empty: pop head; ext_inst <= head, ext_inst_en <= 1, issued_count += 1.
  - FIFO empty: ext_inst <= 32'h0000_0000 (NOP, sll r0,r0,0), ext_inst_en <= 1, bubble_count += 1.
- RUN with run=0 at an edge: go to IDLE; ext_inst <= 0, ext_inst_en <= 0; no pop.
- busy = (state == RUN), registered.
- Latency: an instruction at the FIFO head appears on ext_inst one cycle after the edge that pops it. The core executes it during the cycle it is presented.
- Retire: at the edge ending a cycle in which ext_inst_en=1 and the presented word came from the FIFO (not a bubble):
  - retire_valid <= 1, retire_pc <= pc_current, retire_inst <= ext_inst.
  - Otherwise retire_valid <= 0.
  - Bubbles never retire. Each FIFO instruction retires exactly once, in issue order.
- Counters saturate at all-ones; no wrap.

Optional Feature:
- Macro INJ_AUTOSTOP_EN.
- Defined: in RUN with FIFO empty, no NOP is issued. FSM returns to IDLE, ext_inst_en <= 0, bubble_count stays 0. Re-entry needs run to be 1 at a later edge with the FSM in IDLE (run held high re-enters immediately).
- Not defined: bubble insertion as described above.

Test Plan:
- Reset, then push 3 words 0x2008_0005, 0x2009_0007, 0x0109_5020 with run=0 -> in_ready=1, ext_inst_en=0, issued_count=0.
- Raise run -> ext_inst shows the 3 words on consecutive cycles starting 2 edges after run rises. retire_pc follows core PC 0,4,8 with matching retire_inst. issued_count=3.
- Continue run with FIFO empty for 4 cycles -> ext_inst=0, ext_inst_en=1, bubble_count=4, retire_valid=0. With INJ_AUTOSTOP_EN: ext_inst_en=0, busy=0, bubble_count=0.
- Push 8 words (DEPTH=8), run=0 -> in_ready=0 after 8th. A 9th in_valid is not accepted. Pop via run; in_ready returns 1 the cycle after first pop.
- Simultaneous push/pop at count=4 for 10 cycles -> count stays 4, order preserved across pointer wrap (retire_inst matches push order).
- Assert rst=0 mid-RUN with 5 entries queued -> all outputs zero immediately (async). After release, in_ready=1, FIFO empty, no retire pulse.

Source files
------------

// File: rtl/mips_inst_injector.sv
// mips_inst_injector: FIFO-buffered instruction source for the MIPS core's
// external-instruction port, with a retire trace for scoreboarding.
// Optional macro INJ_AUTOSTOP_EN: stop streaming (return to IDLE) when the
// FIFO runs dry instead of inserting NOP bubbles.
module mips_inst_injector #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  input  logic             run,
  input  logic [31:0]      pc_current,
  output logic [31:0]      ext_inst,
  output logic             ext_inst_en,
  output logic             retire_valid,
  output logic [31:0]      retire_pc,
  output logic [31:0]      retire_inst,
  output logic             busy,
  output logic [CNT_W-1:0] issued_count,
  output logic [CNT_W-1:0] bubble_count
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FILL_W = PTR_W + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_next;
  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FILL_W-1:0] fill;
  logic              full, empty, push, pop;
  logic              inst_real, inst_real_next;
  logic [31:0]       ext_inst_next;
  logic              ext_inst_en_next;
  logic [CNT_W-1:0]  issued_next, bubble_next;
  logic              retire_valid_next;
  logic [31:0]       retire_pc_next, retire_inst_next;

  assign full     = (fill == FILL_W'(DEPTH));
  assign empty    = (fill == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  // FIFO storage; emptied logically by resetting the pointers and fill
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and fill level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Next state, issue decision and counter updates
  always_comb begin
    state_next       = state;
    pop              = 1'b0;
    ext_inst_next    = 32'h0;
    ext_inst_en_next = 1'b0;
    inst_real_next   = 1'b0;
    issued_next      = issued_count;
    bubble_next      = bubble_count;
    case (state)
      IDLE: begin
        if (run) state_next = RUN;
      end
      RUN: begin
        if (!run) begin
          state_next = IDLE;
        end else if (!empty) begin
          pop              = 1'b1;
          ext_inst_next    = mem[rd_ptr];
          ext_inst_en_next = 1'b1;
          inst_real_next   = 1'b1;
          if (issued_count != '1) issued_next = issued_count + CNT_W'(1);
        end else begin
`ifdef INJ_AUTOSTOP_EN
          state_next = IDLE;
`else
          ext_inst_en_next = 1'b1;
          if (bubble_count != '1) bubble_next = bubble_count + CNT_W'(1);
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Retire the word presented this cycle if it came from the FIFO
  always_comb begin
    retire_valid_next = ext_inst_en && inst_real;
    retire_pc_next    = retire_pc;
    retire_inst_next  = retire_inst;
    if (retire_valid_next) begin
      retire_pc_next   = pc_current;
      retire_inst_next = ext_inst;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      ext_inst     <= 32'h0;
      ext_inst_en  <= 1'b0;
      inst_real    <= 1'b0;
      issued_count <= '0;
      bubble_count <= '0;
      retire_valid <= 1'b0;
      retire_pc    <= 32'h0;
      retire_inst  <= 32'h0;
    end else begin
      state        <= state_next;
      busy         <= (state_next == RUN);
      ext_inst     <= ext_inst_next;
      ext_inst_en  <= ext_inst_en_next;
      inst_real    <= inst_real_next;
      issued_count <= issued_next;
      bubble_count <= bubble_next;
      retire_valid <= retire_valid_next;
      retire_pc    <= retire_pc_next;
      retire_inst  <= retire_inst_next;
    end
  end

endmodule

// File: tb/tb_mips_inst_injector.sv
// Directed self-checking bench for mips_inst_injector (DEPTH=8, CNT_W=16).
module tb_mips_inst_injector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_ready;
  logic        run = 1'b0;
  logic [31:0] pc_current = 32'h0;
  logic [31:0] ext_inst;
  logic        ext_inst_en;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retire_inst;
  logic        busy;
  logic [15:0] issued_count;
  logic [15:0] bubble_count;

  int n_checks = 0;
  int n_fail   = 0;

  mips_inst_injector #(.DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .run(run), .pc_current(pc_current),
    .ext_inst(ext_inst), .ext_inst_en(ext_inst_en),
    .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_inst(retire_inst), .busy(busy),
    .issued_count(issued_count), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #2;
    n_checks++;
    if ({ext_inst, ext_inst_en, retire_valid, retire_pc, retire_inst, busy,
         issued_count, bubble_count} !== '0) begin
      n_fail++; $display("FAIL reset_outputs ext=%h en=%b rv=%b busy=%b iss=%0d bub=%0d exp all zero",
                         ext_inst, ext_inst_en, retire_valid, busy, issued_count, bubble_count);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_push3;
    logic [31:0] w [3];
    w[0] = 32'h2008_0005; w[1] = 32'h2009_0007; w[2] = 32'h0109_5020;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = w[i]; tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL push3_in_ready got=%b exp=1", in_ready); end
    n_checks++;
    if (ext_inst_en !== 1'b0) begin n_fail++; $display("FAIL push3_en got=%b exp=0", ext_inst_en); end
    n_checks++;
    if (issued_count !== 16'd0) begin n_fail++; $display("FAIL push3_issued got=%0d exp=0", issued_count); end
  endtask

  task automatic test_stream;
    run = 1'b1; pc_current = 32'h0;
    tick();
    n_checks++;
    if (busy !== 1'b1 || ext_inst_en !== 1'b0) begin
      n_fail++; $display("FAIL stream_enter busy=%b en=%b exp busy=1 en=0", busy, ext_inst_en);
    end
    tick();
    n_checks++;
    if (ext_inst !== 32'h2008_0005 || ext_inst_en !== 1'b1 || issued_count !== 16'd1) begin
      n_fail++; $display("FAIL stream_w0 ext=%h en=%b iss=%0d exp 20080005/1/1", ext_inst, ext_inst_en, issued_count);
    end
    tick();
    pc_current = 32'h4;
    n_checks++;
    if (ext_inst !== 32'h2009_0007 || retire_valid !== 1'b1 || retire_pc !== 32'h0 || retire_inst !== 32'h2008_0005) begin
      n_fail++; $display("FAIL stream_ret0 ext=%h rv=%b rpc=%h ri=%h exp 20090007/1/0/20080005",
                         ext_inst, retire_valid, retire_pc, retire_inst);
    end
    tick();
    pc_current = 32'h8;
    n_checks++;
    if (ext_inst !== 32'h0109_5020 || retire_valid !== 1'b1 || retire_pc !== 32'h4 || retire_inst !== 32'h2009_0007) begin
      n_fail++; $display("FAIL stream_ret1 ext=%h rv=%b rpc=%h ri=%h exp 01095020/1/4/20090007",
                         ext_inst, retire_valid, retire_pc, retire_inst);
    end
    tick();
    n_checks++;
    if (retire_valid !== 1'b1 || retire_pc !== 32'h8 || retire_inst !== 32'h0109_5020 || issued_count !== 16'd3) begin
      n_fail++; $display("FAIL stream_ret2 rv=%b rpc=%h ri=%h iss=%0d exp 1/8/01095020/3",
                         retire_valid, retire_pc, retire_inst, issued_count);
    end
`ifdef INJ_AUTOSTOP_EN
    n_checks++;
    if (ext_inst_en !== 1'b0 || busy !== 1'b0 || bubble_count !== 16'd0) begin
      n_fail++; $display("FAIL autostop_first en=%b busy=%b bub=%0d exp 0/0/0", ext_inst_en, busy, bubble_count);
    end
`else
    n_checks++;
    if (ext_inst !== 32'h0 || ext_inst_en !== 1'b1 || bubble_count !== 16'd1) begin
      n_fail++; $display("FAIL bubble_first ext=%h en=%b bub=%0d exp 0/1/1", ext_inst, ext_inst_en, bubble_count);
    end
`endif
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_no_retire got=%b exp=0", retire_valid); end
`ifdef INJ_AUTOSTOP_EN
    n_checks++;
    if (ext_inst_en !== 1'b0 || bubble_count !== 16'd0) begin
      n_fail++; $display("FAIL autostop_hold en=%b bub=%0d exp 0/0", ext_inst_en, bubble_count);
    end
`else
    n_checks++;
    if (ext_inst !== 32'h0 || ext_inst_en !== 1'b1 || bubble_count !== 16'd4) begin
      n_fail++; $display("FAIL bubble_four ext=%h en=%b bub=%0d exp 0/1/4", ext_inst, ext_inst_en, bubble_count);
    end
`endif
    run = 1'b0;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0 || ext_inst_en !== 1'b0) begin
      n_fail++; $display("FAIL stream_stop busy=%b en=%b exp 0/0", busy, ext_inst_en);
    end
  endtask

  task automatic test_full;
    pc_current = 32'h100;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 32'h1000_0000 + 32'(i); tick();
    end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    in_data = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ninth got=%b exp=0", in_ready); end
    run = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL full_enter rdy=%b busy=%b exp 0/1", in_ready, busy);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || ext_inst !== 32'h1000_0000) begin
      n_fail++; $display("FAIL full_first_pop rdy=%b ext=%h exp 1/10000000", in_ready, ext_inst);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      n_checks++;
      if (ext_inst !== 32'h1000_0000 + 32'(i) || retire_valid !== 1'b1 || retire_inst !== 32'h1000_0000 + 32'(i - 1)) begin
        n_fail++; $display("FAIL full_drain[%0d] ext=%h rv=%b ri=%h exp %h/1/%h", i, ext_inst, retire_valid,
                           retire_inst, 32'h1000_0000 + 32'(i), 32'h1000_0000 + 32'(i - 1));
      end
    end
    run = 1'b0;
    tick();
    n_checks++;
    if (retire_inst !== 32'h1000_0007 || retire_pc !== 32'h100 || ext_inst_en !== 1'b0 || issued_count !== 16'd11) begin
      n_fail++; $display("FAIL full_last ri=%h rpc=%h en=%b iss=%0d exp 10000007/100/0/11",
                         retire_inst, retire_pc, ext_inst_en, issued_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] seq [16];
    for (int k = 0; k < 16; k++) seq[k] = 32'hA000_0000 + 32'(k);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = seq[k]; tick();
    end
    in_valid = 1'b0;
    run = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = seq[4 + k];
      tick();
      n_checks++;
      if (ext_inst !== seq[k] || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_issue[%0d] ext=%h rdy=%b exp %h/1", k, ext_inst, in_ready, seq[k]);
      end
      if (k > 0) begin
        n_checks++;
        if (retire_valid !== 1'b1 || retire_inst !== seq[k - 1]) begin
          n_fail++; $display("FAIL b2b_retire[%0d] rv=%b ri=%h exp 1/%h", k, retire_valid, retire_inst, seq[k - 1]);
        end
      end
    end
    in_valid = 1'b0; run = 1'b0;
    tick();
    n_checks++;
    if (retire_inst !== seq[9] || ext_inst_en !== 1'b0 || issued_count !== 16'd21) begin
      n_fail++; $display("FAIL b2b_end ri=%h en=%b iss=%0d exp %h/0/21", retire_inst, ext_inst_en, issued_count, seq[9]);
    end
    // four entries remain; top up to five while running, then reset
    in_valid = 1'b1; in_data = seq[14]; run = 1'b1;
    tick();
    in_data = seq[15];
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (ext_inst !== seq[10] || ext_inst_en !== 1'b1) begin
      n_fail++; $display("FAIL prereset_issue ext=%h en=%b exp %h/1", ext_inst, ext_inst_en, seq[10]);
    end
  endtask

  task automatic test_reset_mid_run;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({ext_inst, ext_inst_en, retire_valid, retire_pc, retire_inst, busy,
         issued_count, bubble_count} !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrun_reset ext=%h en=%b rv=%b busy=%b iss=%0d rdy=%b exp zeros, rdy=1",
                         ext_inst, ext_inst_en, retire_valid, busy, issued_count, in_ready);
    end
    run = 1'b0;
    #3 rst = 1'b1;
    tick();
    n_checks++;
    if (retire_valid !== 1'b0 || ext_inst_en !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL postreset rv=%b en=%b rdy=%b exp 0/0/1", retire_valid, ext_inst_en, in_ready);
    end
    in_valid = 1'b1; in_data = 32'h3C01_1234;
    tick();
    in_valid = 1'b0; run = 1'b1;
    tick();
    tick();
    n_checks++;
    if (ext_inst !== 32'h3C01_1234 || issued_count !== 16'd1) begin
      n_fail++; $display("FAIL postreset_empty ext=%h iss=%0d exp 3c011234/1", ext_inst, issued_count);
    end
    run = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_push3();
    test_stream();
    test_full();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
